// File: rtl/arb_mux.sv
`default_nettype none
// =============================================================================
// arb_mux : N-input registered selection stage, fixed-priority or round-robin
//           arbitration with grant held across multi-beat bursts.
// Rev 1.0
// =============================================================================
module arb_mux #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  parameter  int MODE   = 0,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_LOCKED = 1'b1;
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_IN - 1);
  localparam logic [SEL_W:0]   NUM_EXT   = (SEL_W + 1)'(NUM_IN);

  logic [0:0]       state;
  logic [SEL_W-1:0] lock_idx;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;
  logic             grant_last;
  logic             free;
  logic             xfer_in;
  logic             xfer_out;

  assign free     = !out_valid || out_ready;
  assign xfer_out = out_valid && out_ready;
  assign xfer_in  = free && grant_valid;

  // Idle scan starts at ptr (round-robin) or 0 (fixed priority), first valid wins.
  always_comb begin : p_grant
    logic             found;
    logic [SEL_W-1:0] cand;
    logic [SEL_W:0]   sum;
    found       = 1'b0;
    cand        = '0;
    sum         = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (state == ST_LOCKED) begin
      grant_idx   = lock_idx;
      grant_valid = in_valid[lock_idx];
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (MODE == 1) begin
          sum = {1'b0, ptr} + (SEL_W + 1)'(k);
          if (sum >= NUM_EXT) begin
            sum = sum - NUM_EXT;
          end
          cand = sum[SEL_W-1:0];
        end else begin
          cand = SEL_W'(k);
        end
        if (!found && in_valid[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
      grant_valid = found;
    end
  end

  assign grant_data = in_data[grant_idx*WIDTH +: WIDTH];
  assign grant_last = in_last[grant_idx];
  assign ptr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);

  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_ready
      assign in_ready[i] = rst_n && xfer_in && (grant_idx == SEL_W'(i));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lock_idx  <= '0;
      ptr       <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (xfer_in) begin
        out_data  <= grant_data;
        out_sel   <= grant_idx;
        out_last  <= grant_last;
        out_valid <= 1'b1;
        if (state == ST_IDLE && !grant_last) begin
          state    <= ST_LOCKED;
          lock_idx <= grant_idx;
        end else if (state == ST_LOCKED && grant_last) begin
          state <= ST_IDLE;
        end
        if (MODE == 1 && grant_last) begin
          ptr <= ptr_next;
        end
      end else if (xfer_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// =============================================================================
// tb_arb_mux : scoreboard bench over four arb_mux configurations.
// Rev 1.0
// =============================================================================
module tb_arb_mux;

  typedef struct {
    logic [63:0] data;
    int          sel;
    bit          last;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    bit          last;
    int          gap;
  } beat_t;

  logic clk;
  int   errors = 0;
  int   checks = 0;
  bit   done [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_cfg
    localparam int K    = k;
    localparam int W    = (k == 2) ? 8 : ((k == 3) ? 64 : 32);
    localparam int N    = (k == 2) ? 2 : ((k == 3) ? 5 : 4);
    localparam int MD   = (k == 0) ? 0 : 1;
    localparam int SW   = $clog2(N);

    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_sel;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    exp_t  exp_q [$];
    beat_t pq [N][$];
    int    ordy_pct;

    // reference model state: burst owner, rotation start, output occupancy
    bit    m_lock;
    int    m_lk;
    int    m_ptr;
    bit    m_full;

    arb_mux #(.WIDTH(W), .NUM_IN(N), .MODE(MD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
    );

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cfg%0d %s: got %0h want %0h (t=%0t)", K, name, got, want, $time);
      end
    endtask

    task automatic add_beat(int c, logic [63:0] d, bit l, int gap);
      beat_t b;
      if (c < N) begin
        b.data = d;
        b.last = l;
        b.gap  = gap;
        pq[c].push_back(b);
      end
    endtask

    task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      #4;
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (acc[c] && pq[c].size() > 0) void'(pq[c].pop_front());
        if (pq[c].size() > 0 && pq[c][0].gap > 0) begin
          pq[c][0].gap = pq[c][0].gap - 1;
          in_valid[c]  = 1'b0;
        end else begin
          in_valid[c] = (pq[c].size() > 0);
        end
        if (pq[c].size() > 0) begin
          in_data[c*W +: W] = pq[c][0].data[W-1:0];
          in_last[c]        = pq[c][0].last;
        end
      end
      out_ready = ($urandom_range(99) < ordy_pct);
    endtask

    function automatic bit busy();
      bit b;
      b = (exp_q.size() > 0);
      for (int c = 0; c < N; c++) if (pq[c].size() > 0) b = 1'b1;
      return b;
    endfunction

    // Reference model: decides the grant for the coming edge from the arbitration rules.
    always @(negedge clk) begin
      int           g;
      int           c;
      logic [N-1:0] exp_rdy;
      exp_t         e;
      g       = -1;
      exp_rdy = '0;
      if (!rst_n) begin
        m_lock = 1'b0;
        m_lk   = 0;
        m_ptr  = 0;
        m_full = 1'b0;
        exp_q.delete();
      end else begin
        if (m_lock) begin
          if (in_valid[m_lk]) g = m_lk;
        end else begin
          for (int j = 0; j < N; j++) begin
            c = (MD == 1) ? (m_ptr + j) % N : j;
            if (g < 0 && in_valid[c]) g = c;
          end
        end
        if (g >= 0 && (!m_full || out_ready)) exp_rdy[g] = 1'b1;
      end
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (rst_n) begin
        if (exp_rdy != '0) begin
          e.data = 64'(in_data[g*W +: W]);
          e.sel  = g;
          e.last = in_last[g];
          exp_q.push_back(e);
          if (!m_lock && !in_last[g]) begin
            m_lock = 1'b1;
            m_lk   = g;
          end else if (m_lock && in_last[g]) begin
            m_lock = 1'b0;
          end
          if (in_last[g]) m_ptr = (g + 1) % N;
          m_full = 1'b1;
        end else if (m_full && out_ready) begin
          m_full = 1'b0;
        end
      end
    end

    // Monitor: every presented beat must match the oldest expected beat.
    always @(negedge clk) begin
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cfg%0d out_beat: got valid beat sel=%0d data=%0h, want no beat (t=%0t)",
                   K, out_sel, out_data, $time);
        end else if (64'(out_data) !== exp_q[0].data || int'(out_sel) != exp_q[0].sel ||
                     out_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL cfg%0d out_beat: got data=%0h sel=%0d last=%0d, want data=%0h sel=%0d last=%0d (t=%0t)",
                   K, out_data, out_sel, out_last, exp_q[0].data, exp_q[0].sel, exp_q[0].last, $time);
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end

    initial begin
      int n;
      rst_n     = 1'b1;
      in_data   = '0;
      in_valid  = '0;
      in_last   = '0;
      out_ready = 1'b0;
      ordy_pct  = 0;
      #1 rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n  = 1'b1;

      // backpressure: first beat parks while the second waits
      add_beat(0, 64'hDEAD_BEEF, 1'b1, 0);
      add_beat(0, 64'h0BAD_F00D_1234_5678, 1'b1, 0);
      ordy_pct = 0;
      repeat (5) step();
      ordy_pct = 100;
      repeat (4) step();

      // asynchronous reset mid-cycle while a beat is held
      add_beat(1, 64'h5555_AAAA_5555_AAAA, 1'b1, 0);
      ordy_pct = 0;
      repeat (3) step();
      chk("held_before_reset", 64'(out_valid), 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      chk("reset_out_sel", 64'(out_sel), 64'd0);
      ordy_pct = 100;
      step();
      step();
      rst_n = 1'b1;
      repeat (3) step();

      // priority: ch1 and ch3 compete, ch1 then drains
      for (int b = 0; b < 4; b++) add_beat(1, 64'h100 + 64'(b), 1'b1, 0);
      for (int b = 0; b < 2; b++) add_beat(3, 64'h300 + 64'(b), 1'b1, 0);
      repeat (9) step();

      // all channels competing with single-beat transfers
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 4; c++) add_beat(c, 64'h1000 * 64'(c) + 64'(b), 1'b1, 0);
      repeat (12) step();

      // ch2 three-beat burst with a bubble before its last beat
      add_beat(0, 64'hA0, 1'b1, 1);
      add_beat(0, 64'hA1, 1'b1, 0);
      add_beat(0, 64'hA2, 1'b1, 0);
      add_beat(2, 64'hC0, 1'b0, 0);
      add_beat(2, 64'hC1, 1'b0, 0);
      add_beat(2, 64'hC2, 1'b1, 1);
      add_beat(3, 64'hD0, 1'b1, 2);
      repeat (14) step();

      ordy_pct = 70;
      repeat (400) begin
        for (int c = 0; c < N; c++) begin
          if (pq[c].size() < 2 && $urandom_range(3) == 0) begin
            int len;
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++)
              add_beat(c, {$urandom, $urandom}, (b == len - 1), ($urandom_range(3) == 0) ? 1 : 0);
          end
        end
        step();
      end

      ordy_pct = 100;
      n = 0;
      while (busy() && n < 300) begin
        step();
        n++;
      end
      chk("drain_pending", 64'(busy()), 64'd0);
      repeat (2) step();
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      done[k] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1] && done[2] && done[3]) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 20000) begin
      errors++;
      $display("FAIL timeout: got %0d cycles without completion, want fewer than 20000", cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_mux.md
# arb_mux

Parametrised N-input, WIDTH-bit registered selection stage with per-channel valid/ready handshakes and a registered output. It replaces the fixed 2:1 operand muxes wherever several producers share one consumer port, for example load/store and fetch requests sharing a memory port. It selects the channel itself, by fixed priority or round-robin, and holds a grant across multi-beat bursts.

## Interface
- WIDTH, 32, data bits per channel
- NUM_IN, 4, number of input channels (≥2)
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- SEL_W, $clog2(NUM_IN), width of channel index (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  per-channel beat valid
- in_last  in  NUM_IN  per-channel last beat of burst; single-beat transfer has in_last=1
- in_ready  out  NUM_IN  per-channel accept; at most one bit high per cycle
- out_data  out  WIDTH  registered selected data
- out_sel  out  SEL_W  registered index of channel that produced out_data
- out_last  out  1  registered copy of accepted in_last
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts out beat

## Operation
- Transfer on input i: in_valid[i] && in_ready[i] at a rising edge. Transfer on output: out_valid && out_ready.
- Output register may load when it is free: free = !out_valid || out_ready.
- State machine:
  - IDLE: eligible set is every channel with in_valid high. Grant the first eligible channel scanning from ptr upward with wrap-around (MODE 1), or from index 0 (MODE 0).
  - LOCKED(lk): only channel lk is eligible. in_ready is 0 for every other channel.
- in_ready[g] = free && in_valid[g] for the granted channel g. All other bits are 0.
- On input transfer from g: out_data <= in_data[g], out_sel <= g, out_last <= in_last[g], out_valid <= 1.
  - In IDLE with in_last[g]=0, go to LOCKED(g).
  - In LOCKED with in_last[g]=1, go to IDLE.
- On output transfer with no input transfer in the same cycle: out_valid <= 0. out_data, out_sel and out_last hold.
- Simultaneous output and input transfer: the register reloads and out_valid stays 1. Full throughput is one beat per cycle.
- Round-robin pointer ptr (SEL_W bits): on a transfer with in_last=1 from channel g, ptr <= (g+1) mod NUM_IN, with wrap NUM_IN-1 → 0. ptr is unused in MODE 0.
- In IDLE the grant is recomputed every cycle. A granted-but-stalled channel may lose the grant to a higher-priority arrival, because no transfer has occurred.
- Producers hold in_valid and in_data stable until accepted. The block does not check this.
- LOCKED with in_valid[lk]=0 (bubble inside a burst): no transfer, and the lock holds.

## Timing
- Reset (rst_n low, takes effect immediately regardless of clk): out_valid=0, out_data=0, out_sel=0, out_last=0, state=IDLE, ptr=0. in_ready is all 0 while rst_n is low.
- Reset mid-burst drops the lock and any held output beat. On release, arbitration restarts from ptr=0.
- Latency: an input beat accepted at edge n is visible on out_* after edge n and is consumable at edge n+1.
- in_ready depends combinationally on in_valid, state, ptr, out_valid and out_ready.
- out_* are driven only from flops. There is no combinational path from in_* to out_*.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and the output register holds its contents.

## Test plan
- Reset/idle: assert rst_n low mid-cycle with out_valid=1 → out_valid=0 and in_ready=0 immediately. After release with no in_valid, out_valid stays 0.
- Fixed priority (MODE 0, NUM_IN=4): in_valid=4'b1010, all in_last=1, out_ready=1.
  - Expect out_sel 1,1,1… while ch1 stays valid.
  - Drop ch1 → out_sel=3 the next cycle.
- Round-robin (MODE 1): all four channels valid with single-beat transfers and out_ready=1 → out_sel sequence 0,1,2,3,0 with one beat per cycle.
- Burst lock (MODE 1): ch2 sends 3 beats (in_last on beat 3) while ch0 is valid throughout.
  - in_ready[0]=0 until the ch2 last beat transfers; ch2 has a 1-cycle bubble mid-burst and the lock holds.
  - Next grant goes to ch3 if valid, else ch0.
- Backpressure: out_ready=0 for 3 cycles with ch0 valid, data 0xDEADBEEF.
  - out_data holds 0xDEADBEEF and in_ready=0.
  - When out_ready rises, the next beat loads in the same cycle and out_valid stays 1.
- Parameter sweep: WIDTH=8/NUM_IN=2 and WIDTH=64/NUM_IN=5 (non-power-of-2) → ptr wraps 4→0 and no out_sel ≥ NUM_IN ever appears.
